// File: rtl/bms_sensor_scanner.sv
// Scans 9 ADC channels (cells 0-3, pack current, temps 0-3) once per scan period and commits
// them as one coherent frame. Define SCANNER_AVG_EN to average two conversions per channel.
module bms_sensor_scanner #(
  parameter int SCAN_PERIOD = 100,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        adc_req,
  output logic [3:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [15:0] adc_data,
  output logic [15:0] cell_voltage [4],
  output logic [15:0] current,
  output logic [7:0]  temp_flag [4],
  output logic        frame_valid,
  output logic        adc_timeout,
  output logic        stale,
  output logic [2:0]  state_dbg
);
  localparam int PCW = $clog2(SCAN_PERIOD);
  localparam int TCW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0] LAST_CH = 4'd8;

  // Handshake: adc_req rises with adc_ch valid and both hold until adc_ack is sampled high on a
  // rising edge, which also samples adc_data; adc_ack seen while adc_req is low is ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_STORE  = 3'd2,
    S_COMMIT = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t         state, next_state;
  logic [PCW-1:0] pcnt;
  logic           start_pending;
  logic [TCW-1:0] tcnt;
  logic [3:0]     ch;
  logic [15:0]    shadow [9];
  logic [15:0]    sample;
  logic           cap_en;
  logic           pair_done;
  logic           scan_start;
  logic           commit_load;

  assign scan_start  = (state == S_IDLE) && start_pending;
  assign commit_load = (state == S_STORE) && (next_state == S_COMMIT);

  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

`ifdef SCANNER_AVG_EN
  logic        second;
  logic [15:0] first_s;
  logic [16:0] sum;

  // second=1 means the first conversion of the pair is held in first_s
  assign sum       = {1'b0, first_s} + {1'b0, adc_data};
  assign sample    = sum[16:1];
  assign cap_en    = second;
  assign pair_done = ~second;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      second  <= 1'b0;
      first_s <= '0;
    end else if (state == S_IDLE) begin
      second <= 1'b0;
    end else if (state == S_REQ && adc_ack) begin
      second  <= ~second;
      first_s <= adc_data;
    end
  end
`else
  assign sample    = adc_data;
  assign cap_en    = 1'b1;
  assign pair_done = 1'b1;
`endif

  // Expiries during a scan collapse into the single pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt          <= '0;
      start_pending <= 1'b1;
    end else begin
      pcnt          <= (pcnt == '0) ? PCW'(SCAN_PERIOD - 1) : pcnt - 1'b1;
      start_pending <= (pcnt == PCW'(1)) | (start_pending & ~scan_start);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start_pending) next_state = S_REQ;
      S_REQ: begin
        if (adc_ack)                                next_state = S_STORE;
        else if (tcnt == TCW'(ACK_TIMEOUT - 1))     next_state = S_ABORT;
      end
      S_STORE:  next_state = (pair_done && ch == LAST_CH) ? S_COMMIT : S_REQ;
      S_COMMIT: next_state = S_IDLE;
      S_ABORT:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    adc_req     = (state == S_REQ);
    frame_valid = (state == S_COMMIT);
    adc_timeout = (state == S_ABORT);
    state_dbg   = state;
  end

  assign adc_ch = ch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      ch   <= '0;
      for (int i = 0; i < 9; i++) shadow[i] <= '0;
    end else begin
      tcnt <= (state == S_REQ) ? tcnt + 1'b1 : '0;
      if (scan_start)
        ch <= '0;
      else if (state == S_STORE && next_state == S_REQ && pair_done)
        ch <= ch + 1'b1;
      if (state == S_REQ && adc_ack && cap_en)
        shadow[ch] <= sample;
    end
  end

  // Outputs load on the edge entering COMMIT so new data and frame_valid appear together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        cell_voltage[i] <= '0;
        temp_flag[i]    <= '0;
      end
      current <= '0;
      stale   <= 1'b1;
    end else if (commit_load) begin
      for (int i = 0; i < 4; i++) begin
        cell_voltage[i] <= shadow[i];
        temp_flag[i]    <= sat8(shadow[5 + i]);
      end
      current <= shadow[4];
      stale   <= 1'b0;
    end else if (state == S_REQ && next_state == S_ABORT) begin
      stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bms_sensor_scanner.sv
// Directed bench for bms_sensor_scanner: ADC responder model plus one task per scenario.
module tb_bms_sensor_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        adc_req;
  logic [3:0]  adc_ch;
  logic        adc_ack = 1'b0;
  logic [15:0] adc_data = '0;
  logic [15:0] cell_voltage [4];
  logic [15:0] current;
  logic [7:0]  temp_flag [4];
  logic        frame_valid;
  logic        adc_timeout;
  logic        stale;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

`ifdef SCANNER_AVG_EN
  localparam int SCAN_CYC = 37;
`else
  localparam int SCAN_CYC = 19;
`endif

  logic [15:0] ch_data  [9];
  logic [15:0] alt_data [9];
  int          ack_delay = 1;
  int          no_ack_ch = -1;
  int          req_cnt   = 0;
  logic [3:0]  prev_ch   = 4'hF;

  bms_sensor_scanner dut (
    .clk(clk), .reset(reset), .adc_req(adc_req), .adc_ch(adc_ch),
    .adc_ack(adc_ack), .adc_data(adc_data), .cell_voltage(cell_voltage),
    .current(current), .temp_flag(temp_flag), .frame_valid(frame_valid),
    .adc_timeout(adc_timeout), .stale(stale), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ADC model: ack in the ack_delay-th REQ cycle; a repeated channel gets alt_data.
  always @(negedge clk) begin
    if (adc_req) begin
      req_cnt = req_cnt + 1;
      if (req_cnt >= ack_delay && int'(adc_ch) != no_ack_ch) begin
        adc_ack  = 1'b1;
        adc_data = (adc_ch == prev_ch) ? alt_data[adc_ch] : ch_data[adc_ch];
        prev_ch  = adc_ch;
      end else begin
        adc_ack = 1'b0;
      end
    end else begin
      req_cnt = 0;
      adc_ack = 1'b0;
    end
  end

  task automatic set_ch(input int c, input logic [15:0] v);
    ch_data[c]  = v;
    alt_data[c] = v;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_frame(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (adc_req !== 1'b0) begin bad++; $display("FAIL reset_adc_req got=%b exp=0", adc_req); end
    total++; if (adc_ch !== 4'd0) begin bad++; $display("FAIL reset_adc_ch got=%0d exp=0", adc_ch); end
    total++; if (frame_valid !== 1'b0 || adc_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got fv=%b to=%b exp=0/0", frame_valid, adc_timeout); end
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL reset_stale got=%b exp=1", stale); end
    total++; if (cell_voltage[0] !== 16'd0 || cell_voltage[3] !== 16'd0 || current !== 16'd0 || temp_flag[0] !== 8'd0) begin
      bad++; $display("FAIL reset_outputs got cv0=%0d cv3=%0d cur=%0d t0=%0d exp=0", cell_voltage[0], cell_voltage[3], current, temp_flag[0]); end
    reset = 1'b1;
  endtask

  task automatic test_first_frame;
    int   n = 0;
    bit   started = 0;
    bit   got = 0;
    bit   seq_ok = 1;
    int   exp_ch = 0;
    logic [3:0] last = 4'hF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_req) begin
        started = 1;
        if (adc_ch !== last) begin
          if (int'(adc_ch) != exp_ch) seq_ok = 0;
          exp_ch++;
          last = adc_ch;
        end
      end
      if (started) n++;
      if (frame_valid) begin got = 1; break; end
    end
    total++; if (!got || n != SCAN_CYC) begin bad++; $display("FAIL first_latency got=%0d exp=%0d", got ? n : -1, SCAN_CYC); end
    total++; if (!seq_ok || exp_ch != 9) begin bad++; $display("FAIL first_ch_seq got_count=%0d ok=%0d exp=9/1", exp_ch, seq_ok); end
    total++; if (cell_voltage[0] !== 16'd3700 || cell_voltage[1] !== 16'd3700 || cell_voltage[2] !== 16'd3700 || cell_voltage[3] !== 16'd3700) begin
      bad++; $display("FAIL first_cells got=%0d/%0d/%0d/%0d exp=3700", cell_voltage[0], cell_voltage[1], cell_voltage[2], cell_voltage[3]); end
    total++; if (current !== 16'd500) begin bad++; $display("FAIL first_current got=%0d exp=500", current); end
    total++; if (temp_flag[0] !== 8'd25 || temp_flag[1] !== 8'd25 || temp_flag[2] !== 8'd25 || temp_flag[3] !== 8'd25) begin
      bad++; $display("FAIL first_temps got=%0d/%0d/%0d/%0d exp=25", temp_flag[0], temp_flag[1], temp_flag[2], temp_flag[3]); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL first_stale got=%b exp=0", stale); end
    @(negedge clk);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL first_fv_width got=%b exp=0", frame_valid); end
  endtask

  task automatic test_update;
    bit got = 0;
    bit held_ok = 1;
    set_ch(1, 16'd4500);
    set_ch(4, 16'd1200);
    set_ch(6, 16'd90);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_valid) begin got = 1; break; end
      if (cell_voltage[1] !== 16'd3700 || current !== 16'd500 || temp_flag[1] !== 8'd25) held_ok = 0;
    end
    total++; if (!held_ok) begin bad++; $display("FAIL update_held got=partial_update exp=held"); end
    total++; if (!got || cell_voltage[1] !== 16'd4500 || current !== 16'd1200 || temp_flag[1] !== 8'd90) begin
      bad++; $display("FAIL update_commit got fv=%0d cv1=%0d cur=%0d t1=%0d exp=1/4500/1200/90", got, cell_voltage[1], current, temp_flag[1]); end
    total++; if (cell_voltage[0] !== 16'd3700 || temp_flag[0] !== 8'd25) begin
      bad++; $display("FAIL update_others got cv0=%0d t0=%0d exp=3700/25", cell_voltage[0], temp_flag[0]); end
  endtask

  task automatic test_timeout;
    int n3 = 0;
    bit got = 0;
    int cyc;
    set_ch(0, 16'd1111);
    no_ack_ch = 3;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (adc_req && adc_ch == 4'd3) n3++;
      if (adc_timeout) begin got = 1; break; end
    end
    total++; if (!got || n3 != 16) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=16", got ? n3 : -1); end
    total++; if (stale !== 1'b1 || frame_valid !== 1'b0) begin bad++; $display("FAIL timeout_stale got=%b fv=%b exp=1/0", stale, frame_valid); end
    total++; if (cell_voltage[0] !== 16'd3700 || cell_voltage[1] !== 16'd4500 || current !== 16'd1200) begin
      bad++; $display("FAIL timeout_held got cv0=%0d cv1=%0d cur=%0d exp=3700/4500/1200", cell_voltage[0], cell_voltage[1], current); end
    no_ack_ch = -1;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_req) begin got = 1; break; end
    end
    total++; if (!got || adc_ch !== 4'd0) begin bad++; $display("FAIL timeout_rescan_ch got=%0d exp=0", got ? int'(adc_ch) : -1); end
    wait_frame(100, cyc);
    total++; if (cyc < 0 || stale !== 1'b0 || cell_voltage[0] !== 16'd1111) begin
      bad++; $display("FAIL timeout_recover got cyc=%0d stale=%b cv0=%0d exp=stale0 cv0=1111", cyc, stale, cell_voltage[0]); end
  endtask

  task automatic test_temp_sat;
    logic [15:0] vals [3];
    logic [7:0]  exps [3];
    int cyc;
    vals[0] = 16'h0150; exps[0] = 8'd255;
    vals[1] = 16'h00FF; exps[1] = 8'd255;
    vals[2] = 16'h0050; exps[2] = 8'd80;
    for (int k = 0; k < 3; k++) begin
      set_ch(7, vals[k]);
      wait_frame(300, cyc);
      total++; if (cyc < 0 || temp_flag[2] !== exps[k]) begin
        bad++; $display("FAIL temp_sat_%0d got=%0d exp=%0d", k, temp_flag[2], exps[k]); end
    end
  endtask

  task automatic test_reset_mid;
    bit got = 0;
    bit fv_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_req && adc_ch == 4'd5) begin got = 1; break; end
    end
    #2 reset = 1'b0;
    #1;
    total++; if (!got || adc_req !== 1'b0) begin bad++; $display("FAIL mid_reset_req got=%b found=%0d exp=0", adc_req, got); end
    total++; if (cell_voltage[0] !== 16'd0 || current !== 16'd0 || temp_flag[2] !== 8'd0 || stale !== 1'b1) begin
      bad++; $display("FAIL mid_reset_outputs got cv0=%0d cur=%0d t2=%0d stale=%b exp=0/0/0/1", cell_voltage[0], current, temp_flag[2], stale); end
    repeat (3) begin
      @(negedge clk);
      if (frame_valid !== 1'b0) fv_seen = 1;
    end
    total++; if (fv_seen) begin bad++; $display("FAIL mid_reset_fv got=1 exp=0"); end
  endtask

  // After a reset release the first scan starts on edge 1 and expiries land on edges 100, 200.
  task automatic test_pending;
    int fv1 = -1, r2 = -1, fv2 = -1, r3 = -1;
    ack_delay = 15;
    do_reset;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (fv1 < 0) begin
        if (frame_valid) begin fv1 = k; ack_delay = 1; end
      end else if (r2 < 0) begin
        if (adc_req) r2 = k;
      end else if (fv2 < 0) begin
        if (frame_valid) fv2 = k;
      end else if (r3 < 0) begin
        if (adc_req) begin r3 = k; break; end
      end
    end
    total++; if (fv1 != 145) begin bad++; $display("FAIL pending_slow_frame got=%0d exp=145", fv1); end
    total++; if (r2 != 147) begin bad++; $display("FAIL pending_restart got=%0d exp=147", r2); end
    total++; if (fv2 != 165) begin bad++; $display("FAIL pending_fast_frame got=%0d exp=165", fv2); end
    total++; if (r3 != 201) begin bad++; $display("FAIL pending_single got=%0d exp=201", r3); end
  endtask

  task automatic test_avg;
    int cyc;
    ack_delay = 1;
    ch_data[0]  = 16'd3700;
    alt_data[0] = 16'd3703;
    do_reset;
    wait_frame(300, cyc);
    total++; if (cyc < 0 || cell_voltage[0] !== 16'd3701) begin
      bad++; $display("FAIL avg_cell0 got=%0d exp=3701", cell_voltage[0]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) set_ch(i, 16'd3700);
    set_ch(4, 16'd500);
    for (int i = 5; i < 9; i++) set_ch(i, 16'd25);
    test_reset;
    test_first_frame;
    test_update;
    test_timeout;
    test_temp_sat;
    test_reset_mid;
`ifdef SCANNER_AVG_EN
    test_avg;
`else
    test_pending;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
